// File: rtl/ntsc_line_scheduler.sv
// NTSC line/field timing sequencer: builds the composite baseband stream
// (sync, blanking, burst gate) locally and pulls upstream pixels only inside
// the active-video window. Timebase advances on every output load and stalls
// only on downstream backpressure.
module ntsc_line_scheduler #(
    parameter int                 LINE_SAMPLES    = 11949,
    parameter int                 HSYNC_SAMPLES   = 883,
    parameter int                 BURST_START     = 1052,
    parameter int                 BURST_SAMPLES   = 470,
    parameter int                 ACTIVE_START    = 2048,
    parameter int                 ACTIVE_SAMPLES  = 9870,
    parameter int                 LINES_PER_FIELD = 262,
    parameter int                 VSYNC_LINES     = 9,
    parameter int                 VBLANK_LINES    = 21,
    parameter logic signed [15:0] SYNC_LEVEL      = -16'sd8192,
    parameter logic signed [15:0] BLANK_LEVEL     = 16'sd0
) (
    input  logic        s00_axis_aclk,
    input  logic        s00_axis_aresetn,
    input  logic [31:0] s00_axis_tdata,
    input  logic        s00_axis_tvalid,
    input  logic        s00_axis_tlast,
    output logic        s00_axis_tready,
    output logic [31:0] m00_axis_tdata,
    output logic        m00_axis_tvalid,
    output logic        m00_axis_tlast,
    output logic [3:0]  m00_axis_tstrb,
    input  logic        m00_axis_tready,
    input  logic        clr_status,
    output logic [15:0] underrun_cnt,
    output logic        align_err
);

    // +1 so that exclusive window ends equal to LINE_SAMPLES still fit
    localparam int SW = $clog2(LINE_SAMPLES + 1);
    localparam int LW = $clog2(LINES_PER_FIELD + 1);

    localparam logic [SW-1:0] S_LAST     = SW'(LINE_SAMPLES - 1);
    localparam logic [SW-1:0] S_VS_END   = SW'(LINE_SAMPLES - HSYNC_SAMPLES);
    localparam logic [SW-1:0] S_HS_END   = SW'(HSYNC_SAMPLES);
    localparam logic [SW-1:0] S_BU_BEG   = SW'(BURST_START);
    localparam logic [SW-1:0] S_BU_END   = SW'(BURST_START + BURST_SAMPLES);
    localparam logic [SW-1:0] S_AC_BEG   = SW'(ACTIVE_START);
    localparam logic [SW-1:0] S_AC_END   = SW'(ACTIVE_START + ACTIVE_SAMPLES);
    localparam logic [SW-1:0] S_AC_LAST  = SW'(ACTIVE_START + ACTIVE_SAMPLES - 1);
    localparam logic [LW-1:0] L_LAST     = LW'(LINES_PER_FIELD - 1);
    localparam logic [LW-1:0] L_VS_END   = LW'(VSYNC_LINES);
    localparam logic [LW-1:0] L_VB_END   = LW'(VBLANK_LINES);

    typedef enum logic [2:0] {
        SEG_VSYNC,
        SEG_HSYNC,
        SEG_BURST,
        SEG_ACTIVE,
        SEG_BLANK
    } seg_t;

    logic [SW-1:0] samp;
    logic [LW-1:0] line;
    seg_t          seg;
    logic          load_en;
    logic          gate;
    logic [15:0]   level;
    logic          accept;
    logic          underrun_ev;
    logic          align_ev;
    logic          last_act_pos;
    logic          unused_ok;

    assign unused_ok      = &{1'b0, s00_axis_tdata[31:16]};
    assign m00_axis_tstrb = 4'hF;

    assign load_en         = !m00_axis_tvalid || m00_axis_tready;
    // Gated by reset so nothing is pulled upstream while the block is held.
    assign s00_axis_tready = s00_axis_aresetn && load_en && (seg == SEG_ACTIVE);
    assign accept          = s00_axis_tvalid && s00_axis_tready;
    assign underrun_ev     = s00_axis_aresetn && load_en && (seg == SEG_ACTIVE) && !s00_axis_tvalid;
    assign last_act_pos    = (line == L_LAST) && (samp == S_AC_LAST);
    // tlast on the wrong pixel, or missing on the last active pixel
    assign align_ev        = accept && (s00_axis_tlast != last_act_pos);

    // Classify the current (line, sample) position, highest priority first
    always_comb begin
        seg = SEG_BLANK;
        if (line < L_VS_END)
            seg = SEG_VSYNC;
        else if (samp < S_HS_END)
            seg = SEG_HSYNC;
        else if (samp >= S_BU_BEG && samp < S_BU_END)
            seg = SEG_BURST;
        else if (line >= L_VB_END && samp >= S_AC_BEG && samp < S_AC_END)
            seg = SEG_ACTIVE;
    end

    // Sample value and burst gate for the current position
    always_comb begin
        level = BLANK_LEVEL;
        gate  = 1'b0;
        case (seg)
            SEG_VSYNC:  level = (samp < S_VS_END) ? SYNC_LEVEL : BLANK_LEVEL;
            SEG_HSYNC:  level = SYNC_LEVEL;
            SEG_BURST:  gate  = 1'b1;
            SEG_ACTIVE: level = s00_axis_tvalid ? s00_axis_tdata[15:0] : BLANK_LEVEL;
            default:    level = BLANK_LEVEL;
        endcase
    end

    // Sample/line timebase; advances only when the output register loads
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            samp <= '0;
            line <= '0;
        end else if (load_en) begin
            if (samp == S_LAST) begin
                samp <= '0;
                line <= (line == L_LAST) ? '0 : line + 1'b1;
            end else begin
                samp <= samp + 1'b1;
            end
        end
    end

    // Output register
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            m00_axis_tdata  <= '0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
        end else if (load_en) begin
            m00_axis_tdata  <= {15'b0, gate, level};
            m00_axis_tvalid <= 1'b1;
            m00_axis_tlast  <= (line == L_LAST) && (samp == S_LAST);
        end
    end

    // Status: an event in the same cycle as clr_status takes precedence
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            underrun_cnt <= '0;
            align_err    <= 1'b0;
        end else begin
            if (underrun_ev)
                underrun_cnt <= clr_status ? 16'd1 :
                                (underrun_cnt == 16'hFFFF) ? 16'hFFFF : underrun_cnt + 16'd1;
            else if (clr_status)
                underrun_cnt <= '0;

            if (align_ev)
                align_err <= 1'b1;
            else if (clr_status)
                align_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ntsc_line_scheduler.sv
// Bench for ntsc_line_scheduler at reduced timing. A beat-index reference
// model (position = beat mod field length) predicts every output, handshake
// and status value; directed phases plus a randomized phase drive it.
module tb_ntsc_line_scheduler;

    localparam int LINE   = 64;
    localparam int HSYNC  = 5;
    localparam int BST    = 7;
    localparam int BSN    = 4;
    localparam int AST    = 14;
    localparam int ASN    = 48;
    localparam int LINES  = 10;
    localparam int VSYNC  = 2;
    localparam int VBLANK = 4;
    localparam int FIELD  = LINE * LINES;
    localparam int LAST_ACT_K = (LINES - 1) * LINE + AST + ASN - 1;
    localparam logic [15:0] SYNC  = 16'hE000;
    localparam logic [15:0] BLANK = 16'h0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] s_dat;
    logic        s_vld;
    logic        s_lst;
    logic        s_rdy;
    logic [31:0] m_dat;
    logic        m_vld;
    logic        m_lst;
    logic [3:0]  m_strb;
    logic        m_rdy;
    logic        clr;
    logic [15:0] ucnt;
    logic        aerr;

    ntsc_line_scheduler #(
        .LINE_SAMPLES(LINE), .HSYNC_SAMPLES(HSYNC), .BURST_START(BST),
        .BURST_SAMPLES(BSN), .ACTIVE_START(AST), .ACTIVE_SAMPLES(ASN),
        .LINES_PER_FIELD(LINES), .VSYNC_LINES(VSYNC), .VBLANK_LINES(VBLANK)
    ) dut (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rstn),
        .s00_axis_tdata(s_dat), .s00_axis_tvalid(s_vld), .s00_axis_tlast(s_lst),
        .s00_axis_tready(s_rdy),
        .m00_axis_tdata(m_dat), .m00_axis_tvalid(m_vld), .m00_axis_tlast(m_lst),
        .m00_axis_tstrb(m_strb), .m00_axis_tready(m_rdy),
        .clr_status(clr), .underrun_cnt(ucnt), .align_err(aerr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          k = 0;        // index of the next beat within the field
    bit          mv = 0;
    logic [31:0] e_data = '0;
    bit          e_last = 0;
    logic [15:0] e_ucnt = '0;
    bit          e_aerr = 0;
    bit          chk_on = 0;

    function automatic bit act(input int kk);
        int ln, sm;
        ln = kk / LINE;
        sm = kk % LINE;
        return ln >= VBLANK && sm >= AST && sm < AST + ASN &&
               !(sm < HSYNC) && !(sm >= BST && sm < BST + BSN);
    endfunction

    always @(posedge clk) begin
        int ln, sm;
        bit g, ev_u, ev_a;
        logic [15:0] d;
        if (!rstn) begin
            mv = 0; k = 0; e_data = '0; e_last = 0; e_ucnt = '0; e_aerr = 0;
        end else begin
            ev_u = 0; ev_a = 0;
            if (!mv || m_rdy) begin
                ln = k / LINE; sm = k % LINE; g = 0; d = BLANK;
                if (ln < VSYNC)
                    d = (sm < LINE - HSYNC) ? SYNC : BLANK;
                else if (sm < HSYNC)
                    d = SYNC;
                else if (sm >= BST && sm < BST + BSN)
                    g = 1;
                else if (act(k)) begin
                    if (s_vld) begin
                        d = s_dat[15:0];
                        ev_a = (s_lst != (k == LAST_ACT_K));
                    end else
                        ev_u = 1;
                end
                e_data = {15'b0, g, d};
                e_last = (k == FIELD - 1);
                mv = 1;
                k = (k + 1) % FIELD;
            end
            if (ev_u)      e_ucnt = clr ? 16'd1 : (e_ucnt == 16'hFFFF ? 16'hFFFF : e_ucnt + 16'd1);
            else if (clr)  e_ucnt = '0;
            if (ev_a)      e_aerr = 1;
            else if (clr)  e_aerr = 0;
        end
    end

    // Per-cycle comparison away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("tdata",    m_dat, e_data);
            chk("tvalid",   32'(m_vld), 32'(mv));
            chk("tlast",    32'(m_lst), 32'(e_last));
            chk("s_tready", 32'(s_rdy), 32'(rstn && (!mv || m_rdy) && act(k)));
            chk("underrun", 32'(ucnt), 32'(e_ucnt));
            chk("align",    32'(aerr), 32'(e_aerr));
            chk("tstrb",    32'(m_strb), 32'hF);
        end
    end

    // ---------------- stimulus ----------------
    int pidx = 0;
    int p0 = 0;
    int tl_cnt = 0;

    task automatic step();
        bit hs;
        @(negedge clk);
        hs = s_vld && s_rdy;
        @(posedge clk);
        #1;
        if (hs) pidx++;
        if (m_lst) tl_cnt++;
    endtask

    // vm: 0 none, 1 always, 2 random, 3 drop 3 beats at line 6 sample 30
    // rm: 0 ready, 1 toggle, 2 random
    // lm: 0 on last active position, 1 on pixel p0+100, 2 random mix
    task automatic run(input int n, input int vm, input int rm, input int lm);
        for (int i = 0; i < n; i++) begin
            case (vm)
                0: s_vld = 0;
                1: s_vld = 1;
                2: s_vld = ($urandom_range(9) != 0);
                default: s_vld = !(k >= 6 * LINE + 30 && k <= 6 * LINE + 32);
            endcase
            case (rm)
                0: m_rdy = 1;
                1: m_rdy = ~m_rdy;
                default: m_rdy = ($urandom_range(3) != 0);
            endcase
            case (lm)
                0: s_lst = (k == LAST_ACT_K);
                1: s_lst = (pidx - p0 == 100);
                default: s_lst = ($urandom_range(149) == 0) ? 1'b1 : (k == LAST_ACT_K);
            endcase
            if (vm == 2) clr = ($urandom_range(99) == 0);
            s_dat = {16'($urandom), 16'(pidx)};
            step();
        end
    endtask

    initial begin
        rstn = 0; s_dat = '0; s_vld = 0; s_lst = 0; m_rdy = 1; clr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1;
        chk("rst_tvalid",  32'(m_vld), 32'd0);
        chk("rst_tdata",   m_dat, 32'd0);
        chk("rst_tlast",   32'(m_lst), 32'd0);
        chk("rst_s_tready", 32'(s_rdy), 32'd0);
        chk("rst_underrun", 32'(ucnt), 32'd0);
        chk("rst_align",   32'(aerr), 32'd0);

        // 1: no input, full field
        rstn = 1;
        run(1, 0, 0, 0);
        chk("s1_tvalid_1cyc", 32'(m_vld), 32'd1);
        chk("s1_first_sync",  m_dat, {16'h0, SYNC});
        tl_cnt = 0;
        run(639, 0, 0, 0);
        chk("s1_underrun_288", 32'(ucnt), 32'd288);
        chk("s1_tlast_once",   32'(tl_cnt), 32'd1);

        // 2: continuous ramp, tlast on the last active pixel
        clr = 1; run(1, 1, 0, 0); clr = 0;
        p0 = pidx;
        run(639, 1, 0, 0);
        chk("s2_pixels_288", 32'(pidx - p0), 32'd288);
        chk("s2_align",    32'(aerr), 32'd0);
        chk("s2_underrun", 32'(ucnt), 32'd0);

        // 3: downstream ready toggling every cycle
        p0 = pidx;
        run(1280, 1, 1, 0);
        chk("s3_pixels_288", 32'(pidx - p0), 32'd288);
        chk("s3_align",    32'(aerr), 32'd0);
        chk("s3_underrun", 32'(ucnt), 32'd0);

        // 4: three-beat input gap on line 6
        clr = 1; run(1, 1, 0, 0); clr = 0;
        p0 = pidx;
        run(639, 3, 0, 0);
        chk("s4_underrun_3", 32'(ucnt), 32'd3);
        chk("s4_pixels_285", 32'(pidx - p0), 32'd285);
        chk("s4_align",      32'(aerr), 32'd0);

        // 5: tlast on pixel 100 -> align error, then clear
        clr = 1; run(1, 1, 0, 0); clr = 0;
        p0 = pidx;
        run(639, 1, 0, 1);
        chk("s5_align_set", 32'(aerr), 32'd1);
        clr = 1; run(1, 0, 0, 0); clr = 0;
        chk("s5_align_clr",    32'(aerr), 32'd0);
        chk("s5_underrun_clr", 32'(ucnt), 32'd0);

        // randomized traffic, backpressure, stray tlast and clears
        run(3000, 2, 2, 2);
        clr = 0;

        // 6: reset at line 5 sample 30
        for (int i = 0; i < 2000 && k != 5 * LINE + 30; i++)
            run(1, 1, 0, 0);
        chk("s6_reach_pos", 32'(k), 32'(5 * LINE + 30));
        rstn = 0;
        s_vld = 1;
        tl_cnt = 0;
        step(); step();
        chk("s6_rst_tvalid", 32'(m_vld), 32'd0);
        rstn = 1;
        run(1, 1, 0, 0);
        chk("s6_first_sync", m_dat, {16'h0, SYNC});
        chk("s6_no_tlast",   32'(tl_cnt), 32'd0);
        run(20, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
